// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the 32-bit SPARC ALU: registers operands at accept,
// strobes the ALU enable for one cycle, captures result/flags and owns the icc register.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  op3,
  input  logic        is_sethi,
  input  logic        i_bit,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [12:0] simm13,
  input  logic [21:0] imm22,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_opcode,
  output logic        alu_en,
  output logic        alu_carry,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        illegal,
  output logic [3:0]  icc
);

  typedef enum logic [1:0] {StIdle, StStrobe, StSample, StDone} state_e;

  localparam logic [5:0] SethiOpcode = 6'b101010;

  state_e      state_q;
  logic [31:0] simm_ext;
  logic [31:0] operand_b;
  logic        cc_op;
  logic        arith_cc;

  function automatic logic op3_supported(input logic [5:0] op);
    case (op)
      6'b000000, 6'b010000, 6'b001000, 6'b011000,
      6'b000100, 6'b010100, 6'b001100, 6'b011100,
      6'b000001, 6'b010001, 6'b000101, 6'b010101,
      6'b000010, 6'b010010, 6'b000110, 6'b010110,
      6'b000011, 6'b010011, 6'b000111, 6'b010111,
      6'b100101, 6'b100110, 6'b100111: op3_supported = 1'b1;
      default:                         op3_supported = 1'b0;
    endcase
  endfunction

  // Operand B selection and cc-op decode from the held opcode
  always_comb begin
    simm_ext  = {{19{simm13[12]}}, simm13};
    operand_b = i_bit ? simm_ext : rs2_data;
    // SETHI's opcode has bit 5 set, so it never qualifies as a cc op
    cc_op     = ~alu_opcode[5] & alu_opcode[4];
    // addcc/subcc/addxcc/subxcc all have op3[1:0] == 00
    arith_cc  = (alu_opcode[1:0] == 2'b00);
  end

  assign issue_ready = (state_q == StIdle);
  // icc only changes in SAMPLE, after the ALU has consumed the carry
  assign alu_carry   = icc[0];

  // Sequencing FSM with registered ALU drive, result and condition codes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      alu_a      <= 32'h0;
      alu_b      <= 32'h0;
      alu_opcode <= 6'h0;
      alu_en     <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= 32'h0;
      illegal    <= 1'b0;
      icc        <= 4'b0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue_valid && !flush) begin
            if (is_sethi) begin
              alu_a      <= rs1_data;
              alu_b      <= {10'b0, imm22};
              alu_opcode <= SethiOpcode;
              alu_en     <= 1'b1;
              state_q    <= StStrobe;
            end else if (op3_supported(op3)) begin
              alu_a      <= rs1_data;
              alu_b      <= operand_b;
              alu_opcode <= op3;
              alu_en     <= 1'b1;
              state_q    <= StStrobe;
            end else begin
              res_valid <= 1'b1;
              illegal   <= 1'b1;
              res_data  <= 32'h0;
              state_q   <= StDone;
            end
          end
        end
        StStrobe: begin
          alu_en  <= 1'b0;
          state_q <= flush ? StIdle : StSample;
        end
        StSample: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            res_data  <= alu_result;
            res_valid <= 1'b1;
            illegal   <= 1'b0;
            if (cc_op) begin
              icc <= arith_cc ? {alu_n, alu_z, alu_v, alu_c} : {alu_n, alu_z, 2'b00};
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (flush || res_ready) begin
            res_valid <= 1'b0;
            illegal   <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  op3;
  logic        is_sethi;
  logic        i_bit;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [12:0] simm13;
  logic [21:0] imm22;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_opcode;
  logic        alu_en;
  logic        alu_carry;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        illegal;
  logic [3:0]  icc;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .op3        (op3),
    .is_sethi   (is_sethi),
    .i_bit      (i_bit),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .simm13     (simm13),
    .imm22      (imm22),
    .flush      (flush),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_en     (alu_en),
    .alu_carry  (alu_carry),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_c      (alu_c),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .illegal    (illegal),
    .icc        (icc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: acts on the rising edge of alu_en
  initial begin
    alu_result = 32'h0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
  end
  always @(posedge alu_en) begin : alu_model
    logic [32:0] s;
    logic        sub;
    s   = 33'h0;
    sub = 1'b0;
    case (alu_opcode)
      6'b000000, 6'b010000: s = {1'b0, alu_a} + {1'b0, alu_b};
      6'b001000, 6'b011000: s = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_carry};
      6'b000100, 6'b010100: begin s = {1'b0, alu_a} - {1'b0, alu_b}; sub = 1'b1; end
      6'b000001, 6'b010001: s = {1'b0, alu_a & alu_b};
      6'b000010, 6'b010010: s = {1'b0, alu_a | alu_b};
      6'b000011, 6'b010011: s = {1'b0, alu_a ^ alu_b};
      6'b100101:            s = {1'b0, alu_a << alu_b[4:0]};
      6'b101010:            s = {1'b0, alu_b << 10};
      default:              s = 33'h0;
    endcase
    alu_result = s[31:0];
    alu_n      = s[31];
    alu_z      = (s[31:0] == 32'h0);
    alu_c      = s[32];
    alu_v      = sub ? ((alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]))
                     : ((alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single cycle; returns at the negedge of cycle 1
  task automatic issue(input logic [5:0] op, input logic sethi, input logic ib,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [12:0] si, input logic [21:0] im);
    op3 = op; is_sethi = sethi; i_bit = ib;
    rs1_data = a; rs2_data = b; simm13 = si; imm22 = im;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // From cycle 1 of a legal op: step to cycle 3 and check the result
  task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_icc);
    @(negedge clk);
    chk({tag, "_c2_en"}, {31'b0, alu_en}, 32'd0);
    chk({tag, "_c2_valid"}, {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_c3_valid"}, {31'b0, res_valid}, 32'd1);
    chk({tag, "_res"}, res_data, exp_res);
    chk({tag, "_icc"}, {28'b0, icc}, {28'b0, exp_icc});
    @(negedge clk);
    chk({tag, "_idle"}, {31'b0, issue_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; op3 = 6'h0; is_sethi = 1'b0; i_bit = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0; simm13 = 13'h0; imm22 = 22'h0;
    flush = 1'b0; res_ready = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, issue_ready}, 32'd1);
    chk("rst_en", {31'b0, alu_en}, 32'd0);
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_icc", {28'b0, icc}, 32'd0);
    chk("rst_res", res_data, 32'h0);
    chk("rst_opc", {26'b0, alu_opcode}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // addcc overflow into sign bit
    issue(6'b010000, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 13'h0, 22'h0);
    chk("addcc_en", {31'b0, alu_en}, 32'd1);
    chk("addcc_opc", {26'b0, alu_opcode}, 32'h10);
    chk("addcc_b", alu_b, 32'h1);
    finish_op("addcc", 32'h80000000, 4'b1010);

    // addcc carry out, then addx consumes it
    issue(6'b010000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 13'h0, 22'h0);
    finish_op("addcc_c", 32'h0, 4'b0101);
    issue(6'b001000, 1'b0, 1'b1, 32'h5, 32'hDEAD, 13'h1FFF, 22'h0);
    chk("addx_carry", {31'b0, alu_carry}, 32'd1);
    chk("addx_b", alu_b, 32'hFFFFFFFF);
    finish_op("addx", 32'h5, 4'b0101);

    // prime icc=0011, then andcc forces V/C low
    issue(6'b010000, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 13'h0, 22'h0);
    finish_op("prime", 32'h7FFFFFFF, 4'b0011);
    issue(6'b010001, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 13'h0, 22'h0);
    finish_op("andcc", 32'h0, 4'b0100);

    // sethi
    issue(6'b111111, 1'b1, 1'b0, 32'h0, 32'h0, 13'h0, 22'h3FFFFF);
    chk("sethi_opc", {26'b0, alu_opcode}, 32'h2A);
    chk("sethi_b", alu_b, 32'h003FFFFF);
    finish_op("sethi", 32'hFFFFFC00, 4'b0100);

    // unsupported op3
    issue(6'b101111, 1'b0, 1'b0, 32'h1234, 32'h5678, 13'h0, 22'h0);
    chk("ill_en", {31'b0, alu_en}, 32'd0);
    chk("ill_valid", {31'b0, res_valid}, 32'd1);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_res", res_data, 32'h0);
    @(negedge clk);
    chk("ill_drop", {31'b0, res_valid}, 32'd0);
    chk("ill_icc", {28'b0, icc}, 32'h4);

    // backpressure: result held for 5 cycles
    res_ready = 1'b0;
    issue(6'b000000, 1'b0, 1'b0, 32'h3, 32'h4, 13'h0, 22'h0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_res", res_data, 32'h7);
      @(negedge clk);
    end
    chk("bp_busy", {31'b0, issue_ready}, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'b0, res_valid}, 32'd0);
    chk("bp_icc", {28'b0, icc}, 32'h4);

    // flush during SAMPLE: addcc 1+1 would clear icc
    issue(6'b010000, 1'b0, 1'b0, 32'h1, 32'h1, 13'h0, 22'h0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", {31'b0, res_valid}, 32'd0);
    chk("fl_ready", {31'b0, issue_ready}, 32'd1);
    chk("fl_icc", {28'b0, icc}, 32'h4);
    @(negedge clk);
    chk("fl_valid2", {31'b0, res_valid}, 32'd0);

    // flush in IDLE blocks a simultaneous issue
    flush = 1'b1;
    issue(6'b010000, 1'b0, 1'b0, 32'h1, 32'h1, 13'h0, 22'h0);
    flush = 1'b0;
    chk("fli_en", {31'b0, alu_en}, 32'd0);
    chk("fli_ready", {31'b0, issue_ready}, 32'd1);

    // async reset mid-STROBE
    issue(6'b010000, 1'b0, 1'b0, 32'h1, 32'h1, 13'h0, 22'h0);
    chk("rs_en_pre", {31'b0, alu_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_en", {31'b0, alu_en}, 32'd0);
    chk("rs_valid", {31'b0, res_valid}, 32'd0);
    chk("rs_icc", {28'b0, icc}, 32'd0);
    chk("rs_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing controller for the 32-bit SPARC ALU. Accepts one decoded format-3 arithmetic, logical or shift instruction (or SETHI) per transaction, selects operands and opcode, and strobes the ALU's enable. It captures the result and flags, owns the architectural integer condition codes (icc = N,Z,V,C), and returns the result over a valid/ready handshake. It sits between the decode stage and register-file writeback.

## Interface
Parameters:
- none; datapath width is fixed at 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction presented
- issue_ready  out  1  controller can accept; high only in IDLE
- op3  in  6  SPARC op3 field
- is_sethi  in  1  SETHI instruction; op3 ignored
- i_bit  in  1  1: operand B = sign-extended simm13; 0: rs2_data
- rs1_data  in  32  operand A
- rs2_data  in  32  register operand B
- simm13  in  13  signed immediate
- imm22  in  22  SETHI immediate
- flush  in  1  abort in-flight operation
- alu_a  out  32  to ALU A_in
- alu_b  out  32  to ALU B_in
- alu_opcode  out  6  to ALU opcode
- alu_en  out  1  to ALU enable (ALU acts on rising edge of this signal)
- alu_carry  out  1  to ALU carry; equals icc C
- alu_result  in  32  ALU result
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flags
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_data  out  32  captured result
- illegal  out  1  with res_valid: unsupported op3, no ALU strobe
- icc  out  4  {N,Z,V,C} architectural condition codes

## Operation
- Supported op3: 000000, 010000, 001000, 011000, 000100, 010100, 001100, 011100, 000001, 010001, 000101, 010101, 000010, 010010, 000110, 010110, 000011, 010011, 000111, 010111, 100101, 100110, 100111.
- Supported op3 values are passed through unchanged on alu_opcode.
- SETHI drives alu_opcode = 101010 and alu_b = {10'b0, imm22}.
- Operand B is {{19{simm13[12]}}, simm13} when i_bit=1, otherwise rs2_data. Shifts use the same selection.
- Operands and opcode are registered at accept and held stable through STROBE and SAMPLE.
- FSM states:
  - IDLE: issue_ready=1. issue_valid accepts; a supported op goes to STROBE, an unsupported one goes to DONE with illegal=1.
  - STROBE: alu_en=1 for exactly one cycle, then SAMPLE.
  - SAMPLE: alu_en=0. Latch alu_result into res_data and update icc, then DONE.
  - DONE: res_valid=1. Outputs are held until res_ready=1, then IDLE.
- icc update happens only in SAMPLE and only when op3[5]=0 and op3[4]=1 (the cc variants):
  - Add/sub cc ops: icc = {alu_n, alu_z, alu_v, alu_c}.
  - Logical cc ops (op3[3:0] in 0001..0111, excluding 0100): N and Z are taken from the ALU; V and C are forced to 0.
  - Non-cc, shift, SETHI and illegal ops leave icc unchanged.
- flush in STROBE or SAMPLE returns to IDLE next cycle: no icc update, no res_valid.
  - flush in DONE drops res_valid.
  - flush in IDLE has no effect; an issue in the same cycle is not accepted.
  - flush wins over every simultaneous event.
- Reset (async, any state): state=IDLE, alu_en=0, res_valid=0, illegal=0, res_data=0, alu_a=0, alu_b=0, alu_opcode=0, icc=4'b0000.

## Timing
- Accept at edge 0. alu_en is high during cycle 1. Capture happens at the end of cycle 2. res_valid rises in cycle 3. Accept-to-valid latency = 3 cycles.
- Illegal op: res_valid=1 with illegal=1 one cycle after accept; res_data=0.
- Back-to-back throughput: one op per 4 cycles when res_ready is held at 1. The next accept is possible the cycle after the DONE handshake.
- alu_en is registered (glitch-free) and never high for two consecutive cycles.
- alu_carry reflects icc C as of accept: addx/subx see the C from the previous cc op.
- res_valid/res_data/illegal are stable while res_ready=0.

## Test plan
- Reset mid-STROBE → same cycle: alu_en=0, res_valid=0, icc=0000, issue_ready=1.
- addcc rs1=32'h7FFFFFFF, rs2=1, i_bit=0 → alu_opcode=010000, single alu_en pulse in cycle 1, res_data=32'h80000000, icc=1010, res_valid in cycle 3.
- Add/addx chain:
  - addcc 32'hFFFFFFFF + 1 → icc C=1.
  - Then addx 5 + simm13=13'h1FFF (−1) → alu_carry=1, res_data=5, icc unchanged.
- andcc 32'hF0F0F0F0 & 32'h0F0F0F0F with prior icc=0011 → res_data=0, icc=0100.
- sethi imm22=22'h3FFFFF → alu_b=32'h003FFFFF, res_data=32'hFFFFFC00, icc unchanged.
- Unsupported op3 101111 → no alu_en, illegal=1 and res_valid in cycle 1.
- Backpressure and flush:
  - res_ready=0 for 5 cycles → outputs held.
  - flush during SAMPLE → no res_valid, icc unchanged.
